// File: rtl/microseq_pkg.sv
// Shared definitions for the microprogram sequencer: op encodings and error-flag bit positions.
package microseq_pkg;

  localparam logic [3:0] OP_CONT  = 4'd0;
  localparam logic [3:0] OP_JMP   = 4'd1;
  localparam logic [3:0] OP_JAR   = 4'd2;
  localparam logic [3:0] OP_CALL  = 4'd3;
  localparam logic [3:0] OP_RET   = 4'd4;
  localparam logic [3:0] OP_CASE  = 4'd5;
  localparam logic [3:0] OP_LDAR  = 4'd6;
  localparam logic [3:0] OP_HOLD  = 4'd7;
  localparam logic [3:0] OP_LDCNT = 4'd8;
  localparam logic [3:0] OP_LOOP  = 4'd9;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UNF = 1;
  localparam int unsigned ERR_W   = 2;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO. Callers must not push when full or pop when empty.
module microseq_stack #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] din_i,
  output logic [ADDR_W-1:0] tos_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0]  level_q, level_d;

  always_comb begin
    level_d = level_q;
    if (push_i) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_i) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      level_q <= level_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (LVL_W'(i) == level_q)) mem_q[i] <= din_i;
      end
    end
  end

  // Top of stack is the entry just below the current level.
  always_comb begin
    tos_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LVL_W'(i + 1) == level_q) tos_o = mem_q[i];
    end
  end

  assign level_o = level_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/microseq.sv
// Microprogram sequencer: next microcode address from pipeline fields and internal state.
// Optional loop counter (ops LDCNT/LOOP) enabled by defining MICROSEQ_LOOP_EN.
module microseq
  import microseq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned NUM_COND    = 8,
  parameter int unsigned OR_W        = 4,
  localparam int unsigned LVL_W      = $clog2(STACK_DEPTH + 1),
  localparam int unsigned CSEL_W     = (NUM_COND > 1) ? $clog2(NUM_COND) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        seq_op_i,
  input  logic [ADDR_W-1:0] d_in_i,
  input  logic [ADDR_W-1:0] r_in_i,
  input  logic [OR_W-1:0]   or_in_i,
  input  logic [NUM_COND-1:0] cond_in_i,
  input  logic [CSEL_W-1:0] cond_sel_i,
  input  logic              cond_pol_i,
  input  logic              clear_err_i,
  output logic [ADDR_W-1:0] y_o,
  output logic [LVL_W-1:0]  stack_level_o,
  output logic              stack_ovf_o,
  output logic              stack_unf_o
);

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [ERR_W-1:0]  err_q, err_d, err_set;
  logic [ADDR_W-1:0] y, tos;
  logic              cond, push, pop, full, empty, hold;
`ifdef MICROSEQ_LOOP_EN
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`endif

  assign cond = cond_in_i[cond_sel_i] ^ cond_pol_i;

  microseq_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (upc_q + ADDR_W'(1)),
    .tos_o   (tos),
    .level_o (stack_level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    y       = upc_q;
    hold    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ar_d    = ar_q;
    err_set = '0;
`ifdef MICROSEQ_LOOP_EN
    cnt_d   = cnt_q;
`endif
    case (seq_op_i)
      OP_JMP:  if (cond) y = d_in_i;
      OP_JAR:  y = ar_q;
      OP_CALL: begin
        if (cond) begin
          y = d_in_i;
          if (full) err_set[ERR_OVF] = 1'b1;
          else      push = 1'b1;
        end
      end
      OP_RET: begin
        if (cond) begin
          if (empty) begin
            err_set[ERR_UNF] = 1'b1;
          end else begin
            y   = tos;
            pop = 1'b1;
          end
        end
      end
      OP_CASE: y = d_in_i | ADDR_W'(or_in_i);
      OP_LDAR: ar_d = r_in_i;
      OP_HOLD: hold = 1'b1;
`ifdef MICROSEQ_LOOP_EN
      OP_LDCNT: cnt_d = d_in_i;
      OP_LOOP: begin
        if (empty) begin
          err_set[ERR_UNF] = 1'b1;
        end else if (cnt_q != '0) begin
          y     = tos;
          cnt_d = cnt_q - ADDR_W'(1);
        end else begin
          pop = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    upc_d = hold ? upc_q : y + ADDR_W'(1);
    // A same-cycle clear wins over a newly detected error.
    err_d = clear_err_i ? '0 : (err_q | err_set);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upc_q <= '0;
      ar_q  <= '0;
      err_q <= '0;
`ifdef MICROSEQ_LOOP_EN
      cnt_q <= '0;
`endif
    end else begin
      upc_q <= upc_d;
      ar_q  <= ar_d;
      err_q <= err_d;
`ifdef MICROSEQ_LOOP_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  // Address is forced to zero for as long as reset is held.
  assign y_o         = rst_ni ? y : '0;
  assign stack_ovf_o = err_q[ERR_OVF];
  assign stack_unf_o = err_q[ERR_UNF];

endmodule

// File: tb/tb_microseq.sv
// Randomized self-checking bench for microseq against a queue-based reference model.
module tb_microseq;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MASK   = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        op;
  logic [ADDR_W-1:0] d_in, r_in;
  logic [3:0]        or_in;
  logic [7:0]        cond_in;
  logic [2:0]        cond_sel;
  logic              cond_pol, clear_err;
  logic [ADDR_W-1:0] y;
  logic [2:0]        lvl;
  logic              ovf, unf;

  microseq #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (DEPTH),
    .NUM_COND    (8),
    .OR_W        (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .seq_op_i      (op),
    .d_in_i        (d_in),
    .r_in_i        (r_in),
    .or_in_i       (or_in),
    .cond_in_i     (cond_in),
    .cond_sel_i    (cond_sel),
    .cond_pol_i    (cond_pol),
    .clear_err_i   (clear_err),
    .y_o           (y),
    .stack_level_o (lvl),
    .stack_ovf_o   (ovf),
    .stack_unf_o   (unf)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  int unsigned m_upc, m_ar, m_cnt;
  int unsigned m_stk[$];
  bit          m_ovf, m_unf;
  logic [ADDR_W-1:0] obs_y;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_upc = 0; m_ar = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  // Drive one op, check y and current state before the edge, then advance the model.
  task automatic step(input logic [3:0] o, input int unsigned d, input int unsigned r,
                      input int unsigned orv, input logic [7:0] cnd, input logic [2:0] sel,
                      input logic pol, input logic clr);
    int unsigned ey;
    bit c, set_ovf, set_unf, do_push, do_pop, hold;
    set_ovf = 0; set_unf = 0; do_push = 0; do_pop = 0; hold = 0;
    op = o; d_in = ADDR_W'(d); r_in = ADDR_W'(r); or_in = 4'(orv);
    cond_in = cnd; cond_sel = sel; cond_pol = pol; clear_err = clr;
    #1;
    c  = cnd[sel] ^ pol;
    ey = m_upc;
    case (o)
      4'd1: if (c) ey = d;
      4'd2: ey = m_ar;
      4'd3: if (c) begin
        ey = d;
        if (m_stk.size() == DEPTH) set_ovf = 1; else do_push = 1;
      end
      4'd4: if (c) begin
        if (m_stk.size() == 0) set_unf = 1;
        else begin ey = m_stk[$]; do_pop = 1; end
      end
      4'd5: ey = d | orv;
      4'd7: hold = 1;
`ifdef MICROSEQ_LOOP_EN
      4'd9: begin
        if (m_stk.size() == 0) set_unf = 1;
        else if (m_cnt != 0) ey = m_stk[$];
        else do_pop = 1;
      end
`endif
      default: ;
    endcase
    check_eq($sformatf("y op%0d", o), 32'(y), ey);
    check_eq("stack_level", 32'(lvl), m_stk.size());
    check_eq("stack_ovf", 32'(ovf), 32'(m_ovf));
    check_eq("stack_unf", 32'(unf), 32'(m_unf));
    obs_y = y;
    @(posedge clk);
    #1;
    if (o == 4'd6) m_ar = r;
`ifdef MICROSEQ_LOOP_EN
    if (o == 4'd8) m_cnt = d;
    if (o == 4'd9 && m_stk.size() != 0 && m_cnt != 0) m_cnt = m_cnt - 1;
`endif
    if (do_push) m_stk.push_back((m_upc + 1) & MASK);
    if (do_pop) void'(m_stk.pop_back());
    if (!hold) m_upc = (ey + 1) & MASK;
    if (clr) begin
      m_ovf = 0; m_unf = 0;
    end else begin
      m_ovf = m_ovf | set_ovf;
      m_unf = m_unf | set_unf;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    op = 4'd1; d_in = 11'h155; r_in = '0; or_in = '0;
    cond_in = 8'hFF; cond_sel = 3'd0; cond_pol = 1'b0; clear_err = 1'b0;
    #1;
    check_eq("reset y", 32'(y), 32'h0);
    check_eq("reset level", 32'(lvl), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset y held", 32'(y), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned hold_y;
    do_reset();

    for (int i = 0; i < 3; i++) begin
      step(4'd0, 0, 0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
      check_eq("cont after reset", 32'(obs_y), i);
    end

    step(4'd1, 'h2A0, 0, 0, 8'h04, 3'd2, 1'b0, 1'b0);
    check_eq("jmp taken", 32'(obs_y), 32'h2A0);
    step(4'd0, 0, 0, 0, 8'h04, 3'd2, 1'b0, 1'b0);
    check_eq("cont after jmp", 32'(obs_y), 32'h2A1);
    step(4'd1, 'h2A0, 0, 0, 8'h04, 3'd2, 1'b1, 1'b0);
    check_eq("jmp not taken", 32'(obs_y), 32'h2A2);

    step(4'd1, 'h00F, 0, 0, 8'hFF, 3'd0, 1'b0, 1'b0);
    step(4'd3, 'h100, 0, 0, 8'hFF, 3'd0, 1'b0, 1'b0);
    check_eq("call target", 32'(obs_y), 32'h100);
    step(4'd4, 0, 0, 0, 8'hFF, 3'd0, 1'b0, 1'b0);
    check_eq("ret address", 32'(obs_y), 32'h011);

    for (int i = 0; i < 5; i++) step(4'd3, 'h100 + i, 0, 0, 8'hFF, 3'd1, 1'b0, 1'b0);
    check_eq("ovf after 5 calls", 32'(ovf), 32'h1);
    check_eq("level after 5 calls", 32'(lvl), 32'h4);
    step(4'd0, 0, 0, 0, 8'h00, 3'd0, 1'b0, 1'b1);
    step(4'd3, 'h120, 0, 0, 8'hFF, 3'd1, 1'b0, 1'b1);
    check_eq("clear beats ovf", 32'(ovf), 32'h0);

    for (int i = 0; i < 5; i++) step(4'd4, 0, 0, 0, 8'hFF, 3'd7, 1'b0, 1'b0);
    check_eq("unf on empty ret", 32'(unf), 32'h1);
    step(4'd0, 0, 0, 0, 8'h00, 3'd0, 1'b0, 1'b1);

    step(4'd5, 'h130, 0, 'b0101, 8'h00, 3'd0, 1'b0, 1'b0);
    check_eq("case or", 32'(obs_y), 32'h135);
    step(4'd6, 0, 'h7FF, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    step(4'd2, 0, 0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    check_eq("jar", 32'(obs_y), 32'h7FF);
    step(4'd0, 0, 0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    check_eq("upc wrap", 32'(obs_y), 32'h000);

    step(4'd3, 'h050, 0, 0, 8'hFF, 3'd0, 1'b0, 1'b0);
    hold_y = m_upc;
    for (int i = 0; i < 3; i++) begin
      step(4'd7, 0, 0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
      check_eq("hold", 32'(obs_y), hold_y);
    end
    op = 4'd7;
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset mid-hold y", 32'(y), 32'h0);
    check_eq("reset mid-hold level", 32'(lvl), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MICROSEQ_LOOP_EN
    step(4'd3, 'h200, 0, 0, 8'hFF, 3'd0, 1'b0, 1'b0);
    hold_y = m_stk[$];
    step(4'd8, 2, 0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    step(4'd9, 0, 0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    check_eq("loop 1", 32'(obs_y), hold_y);
    step(4'd9, 0, 0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    check_eq("loop 2", 32'(obs_y), hold_y);
    step(4'd9, 0, 0, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    check_eq("loop exit", 32'(obs_y), (hold_y + 1) & MASK);
    check_eq("loop pop level", 32'(lvl), 32'h0);
`endif

    for (int i = 0; i < 600; i++) begin
      step(4'($urandom_range(0, 15)), $urandom_range(0, MASK), $urandom_range(0, MASK),
           $urandom_range(0, 15), 8'($urandom), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
